// File: rtl/ysyx_25040109_regfile_csr.sv
// ysyx_25040109_regfile_csr
//   General-purpose register file plus a minimal machine-mode CSR block
//   (mstatus, mtvec, mscratch, mepc, mcause, mcycle[h], minstret[h]).
//
// Parameters
//   NREGS      GPR count (16 for RV32E, 32 for RV32I)
//   BYPASS     1 = forward a legal same-cycle GPR write to the read ports
//   MTVEC_RST  reset value of mtvec
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   wen, waddr, wdata           GPR write port
//   raddr1/2 -> rdata1/2        combinational GPR reads
//   a0_out                      current x10
//   csr_we, csr_addr, csr_wdata CSR write port; csr_rdata reads csr_addr
//   trap_valid, trap_pc, trap_cause   exception entry
//   mret, retire                trap return, instruction retired
//   mepc_out, mtvec_out, mie_out      architectural state taps
module ysyx_25040109_regfile_csr #(
    parameter int          NREGS     = 32,
    parameter bit          BYPASS    = 1'b0,
    parameter logic [31:0] MTVEC_RST = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wen,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    output logic [31:0] a0_out,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    input  logic        trap_valid,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic        mret,
    input  logic        retire,
    output logic [31:0] mepc_out,
    output logic [31:0] mtvec_out,
    output logic        mie_out
);

    localparam int AW = $clog2(NREGS);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;

    // ---------------------------------------------------------------- GPRs
    logic [31:0] gpr [NREGS];
    logic        wr_ok;

    assign wr_ok = wen && (waddr != 5'd0) && (32'(waddr) < NREGS);

    function automatic logic [31:0] gpr_read(input logic [4:0] a);
        if (a == 5'd0 || 32'(a) >= NREGS)
            return 32'd0;
        else if (BYPASS && wr_ok && a == waddr)
            return wdata;
        else
            return gpr[a[AW-1:0]];
    endfunction

    assign rdata1 = gpr_read(raddr1);
    assign rdata2 = gpr_read(raddr2);
    assign a0_out = gpr[10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                gpr[i] <= 32'd0;
        end else if (wr_ok) begin
            gpr[waddr[AW-1:0]] <= wdata;
        end
    end

    // ---------------------------------------------------------------- CSRs
    logic        mie, mpie;
    logic [31:0] mtvec, mscratch, mepc, mcause;
    logic [31:0] mcycle_lo, mcycle_hi, minstret_lo, minstret_hi;
    logic [31:0] mcycle_lo_n, mcycle_hi_n, minstret_lo_n, minstret_hi_n;
    logic [31:0] mstatus_rd;

    logic we_mstatus, we_mtvec, we_mscratch, we_mepc, we_mcause;
    logic we_mcycle, we_mcycleh, we_minstret, we_minstreth;

    assign we_mstatus   = csr_we && csr_addr == A_MSTATUS;
    assign we_mtvec     = csr_we && csr_addr == A_MTVEC;
    assign we_mscratch  = csr_we && csr_addr == A_MSCRATCH;
    assign we_mepc      = csr_we && csr_addr == A_MEPC;
    assign we_mcause    = csr_we && csr_addr == A_MCAUSE;
    assign we_mcycle    = csr_we && csr_addr == A_MCYCLE;
    assign we_mcycleh   = csr_we && csr_addr == A_MCYCLEH;
    assign we_minstret  = csr_we && csr_addr == A_MINSTRET;
    assign we_minstreth = csr_we && csr_addr == A_MINSTRETH;

    // MPP is hardwired to machine mode; only MIE/MPIE are stored.
    assign mstatus_rd = 32'h0000_1800 | (32'(mpie) << 7) | (32'(mie) << 3);

    // Counter next-state: a write to one half replaces that half's increment
    // and suppresses any carry into the high half for that cycle.
    always_comb begin
        mcycle_lo_n = we_mcycle ? csr_wdata : mcycle_lo + 32'd1;
        mcycle_hi_n = mcycle_hi;
        if (we_mcycleh)
            mcycle_hi_n = csr_wdata;
        else if (!we_mcycle && mcycle_lo == 32'hFFFF_FFFF)
            mcycle_hi_n = mcycle_hi + 32'd1;

        minstret_lo_n = minstret_lo;
        if (we_minstret)
            minstret_lo_n = csr_wdata;
        else if (retire)
            minstret_lo_n = minstret_lo + 32'd1;
        minstret_hi_n = minstret_hi;
        if (we_minstreth)
            minstret_hi_n = csr_wdata;
        else if (retire && !we_minstret && minstret_lo == 32'hFFFF_FFFF)
            minstret_hi_n = minstret_hi + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie         <= 1'b0;
            mpie        <= 1'b0;
            mtvec       <= MTVEC_RST;
            mscratch    <= 32'd0;
            mepc        <= 32'd0;
            mcause      <= 32'd0;
            mcycle_lo   <= 32'd0;
            mcycle_hi   <= 32'd0;
            minstret_lo <= 32'd0;
            minstret_hi <= 32'd0;
        end else begin
            // trap beats mret beats a software write on the trap-owned CSRs
            if (trap_valid) begin
                mpie <= mie;
                mie  <= 1'b0;
            end else if (mret) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end else if (we_mstatus) begin
                mie  <= csr_wdata[3];
                mpie <= csr_wdata[7];
            end

            if (trap_valid)
                mepc <= trap_pc & ~32'h3;
            else if (we_mepc)
                mepc <= csr_wdata & ~32'h3;

            if (trap_valid)
                mcause <= trap_cause;
            else if (we_mcause)
                mcause <= csr_wdata;

            if (we_mtvec)
                mtvec <= csr_wdata;
            if (we_mscratch)
                mscratch <= csr_wdata;

            mcycle_lo   <= mcycle_lo_n;
            mcycle_hi   <= mcycle_hi_n;
            minstret_lo <= minstret_lo_n;
            minstret_hi <= minstret_hi_n;
        end
    end

    always_comb begin
        csr_rdata = 32'd0;
        case (csr_addr)
            A_MSTATUS:   csr_rdata = mstatus_rd;
            A_MTVEC:     csr_rdata = mtvec;
            A_MSCRATCH:  csr_rdata = mscratch;
            A_MEPC:      csr_rdata = mepc;
            A_MCAUSE:    csr_rdata = mcause;
            A_MCYCLE:    csr_rdata = mcycle_lo;
            A_MINSTRET:  csr_rdata = minstret_lo;
            A_MCYCLEH:   csr_rdata = mcycle_hi;
            A_MINSTRETH: csr_rdata = minstret_hi;
            default:     csr_rdata = 32'd0;
        endcase
    end

    assign mepc_out  = mepc;
    assign mtvec_out = {mtvec[31:2], 2'b00};
    assign mie_out   = mie;

endmodule

// File: tb/tb_ysyx_25040109_regfile_csr.sv
module tb_ysyx_25040109_regfile_csr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1, raddr2;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        trap_valid;
    logic [31:0] trap_pc, trap_cause;
    logic        mret, retire;

    logic [31:0] rdata1, rdata2, a0_out, csr_rdata, mepc_out, mtvec_out;
    logic        mie_out;
    logic [31:0] b_rdata1, b_rdata2, b_a0_out, b_csr_rdata, b_mepc_out, b_mtvec_out;
    logic        b_mie_out;

    always #5 clk = ~clk;

    ysyx_25040109_regfile_csr #(.NREGS(32), .BYPASS(1'b0), .MTVEC_RST(32'h8000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .a0_out(a0_out),
        .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
        .mret(mret), .retire(retire),
        .mepc_out(mepc_out), .mtvec_out(mtvec_out), .mie_out(mie_out)
    );

    ysyx_25040109_regfile_csr #(.NREGS(16), .BYPASS(1'b1), .MTVEC_RST(32'h8000_0000)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(b_rdata1), .rdata2(b_rdata2),
        .a0_out(b_a0_out),
        .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(b_csr_rdata),
        .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
        .mret(mret), .retire(retire),
        .mepc_out(b_mepc_out), .mtvec_out(b_mtvec_out), .mie_out(b_mie_out)
    );

    // Scoreboard: selector codes
    // 0 rdata1  1 rdata2  2 csr_rdata  3 a0_out  4 mepc_out  5 mtvec_out
    // 6 mie_out 7 b_rdata1 8 b_rdata2 (16-entry, bypassing instance)
    int          sel_q[$];
    logic [31:0] exp_q[$];
    string       name_q[$];
    int          n_total = 0;
    int          n_pass  = 0;
    bit          done    = 1'b0;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:       return rdata1;
            1:       return rdata2;
            2:       return csr_rdata;
            3:       return a0_out;
            4:       return mepc_out;
            5:       return mtvec_out;
            6:       return {31'd0, mie_out};
            7:       return b_rdata1;
            8:       return b_rdata2;
            default: return 32'hXXXX_XXXX;
        endcase
    endfunction

    task automatic expect_val(input int sel, input logic [31:0] v, input string n);
        sel_q.push_back(sel);
        exp_q.push_back(v);
        name_q.push_back(n);
    endtask

    // Monitor: outputs are stable mid-cycle; drain everything queued for this cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (sel_q.size() > 0) begin
                int          s;
                logic [31:0] e, a;
                string       n;
                s = sel_q.pop_front();
                e = exp_q.pop_front();
                n = name_q.pop_front();
                a = observe(s);
                n_total++;
                if (a === e)
                    n_pass++;
                else
                    $display("FAIL %s: got 0x%08h expected 0x%08h", n, a, e);
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        csr_we    = 1'b1;
        csr_addr  = a;
        csr_wdata = d;
        step();
        csr_we    = 1'b0;
    endtask

    task automatic csr_chk(input logic [11:0] a, input logic [31:0] e, input string n);
        csr_addr = a;
        expect_val(2, e, n);
        step();
    endtask

    task automatic gpr_wr(input logic [4:0] a, input logic [31:0] d);
        wen   = 1'b1;
        waddr = a;
        wdata = d;
        step();
        wen   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wen = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
        csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
        trap_valid = 1'b0; trap_pc = '0; trap_cause = '0; mret = 1'b0; retire = 1'b0;
        step();

        // reset state
        expect_val(5, 32'h8000_0000, "rst_mtvec_out");
        expect_val(6, 32'd0, "rst_mie");
        expect_val(3, 32'd0, "rst_a0");
        csr_chk(12'h300, 32'h0000_1800, "rst_mstatus");
        csr_chk(12'hB00, 32'd0, "rst_mcycle_held");

        // first mcycle increment on the first edge after release
        rst_n    = 1'b1;
        csr_addr = 12'hB00;
        expect_val(2, 32'd0, "mcycle_at_release");
        step();
        expect_val(2, 32'd1, "mcycle_first_inc");
        step();

        // GPR write/read, x0 hardwired
        gpr_wr(5'd5, 32'hDEAD_BEEF);
        wen = 1'b1; waddr = 5'd0; wdata = 32'h0000_1234;
        step();
        wen = 1'b0; raddr1 = 5'd5; raddr2 = 5'd0;
        expect_val(0, 32'hDEAD_BEEF, "x5_read");
        expect_val(1, 32'd0, "x0_read");
        expect_val(7, 32'hDEAD_BEEF, "rv32e_x5_read");
        step();
        gpr_wr(5'd10, 32'h0000_0055);
        expect_val(3, 32'h0000_0055, "a0_out");
        gpr_wr(5'd20, 32'h0000_0777);
        raddr1 = 5'd20;
        expect_val(0, 32'h0000_0777, "x20_read_32");
        expect_val(7, 32'd0, "x20_read_16");
        step();
        gpr_wr(5'd15, 32'h0000_0F0F);
        raddr2 = 5'd15;
        expect_val(8, 32'h0000_0F0F, "rv32e_x15_read");
        step();

        // same-cycle write/read forwarding
        wen = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_A5A5; raddr1 = 5'd7;
        expect_val(0, 32'd0, "no_bypass_old");
        expect_val(7, 32'hA5A5_A5A5, "bypass_new");
        step();
        wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr1 = 5'd0;
        expect_val(7, 32'd0, "bypass_x0_blocked");
        step();
        wen = 1'b0; raddr1 = 5'd7;
        expect_val(0, 32'hA5A5_A5A5, "x7_committed");
        step();

        // mstatus field masking
        csr_wr(12'h300, 32'hFFFF_FFFF);
        csr_chk(12'h300, 32'h0000_1888, "mstatus_all_ones");
        csr_wr(12'h300, 32'h0000_0008);
        expect_val(6, 32'd1, "mie_set");
        csr_chk(12'h300, 32'h0000_1808, "mstatus_mie");

        // trap with concurrent mcause write: trap wins
        trap_valid = 1'b1; trap_pc = 32'h8000_0123; trap_cause = 32'd11;
        csr_wr(12'h342, 32'd5);
        trap_valid = 1'b0;
        expect_val(4, 32'h8000_0120, "trap_mepc");
        expect_val(6, 32'd0, "trap_mie");
        csr_chk(12'h342, 32'd11, "trap_mcause");
        csr_chk(12'h341, 32'h8000_0120, "trap_mepc_csr");
        csr_chk(12'h300, 32'h0000_1880, "trap_mstatus");
        mret = 1'b1;
        csr_chk(12'h300, 32'h0000_1880, "mstatus_pre_mret");
        mret = 1'b0;
        expect_val(6, 32'd1, "mret_mie");
        csr_chk(12'h300, 32'h0000_1888, "mret_mstatus");

        // mret beats a mstatus write
        csr_wr(12'h300, 32'h0000_0080);
        mret = 1'b1;
        csr_wr(12'h300, 32'h0000_0000);
        mret = 1'b0;
        csr_chk(12'h300, 32'h0000_1888, "mret_over_write");

        // trap beats mret; unrelated CSR write still lands
        trap_valid = 1'b1; mret = 1'b1; trap_pc = 32'h0000_0042; trap_cause = 32'd2;
        csr_wr(12'h340, 32'hCAFE_F00D);
        trap_valid = 1'b0; mret = 1'b0;
        csr_chk(12'h300, 32'h0000_1880, "trap_over_mret");
        csr_chk(12'h340, 32'hCAFE_F00D, "mscratch_same_cycle");
        expect_val(4, 32'h0000_0040, "trap2_mepc");
        step();

        // mepc / mtvec alignment, unimplemented CSR
        csr_wr(12'h341, 32'h1234_5677);
        expect_val(4, 32'h1234_5674, "mepc_write_align");
        step();
        csr_wr(12'h305, 32'h0000_1003);
        expect_val(5, 32'h0000_1000, "mtvec_out_align");
        csr_chk(12'h305, 32'h0000_1003, "mtvec_read");
        csr_wr(12'h7C0, 32'h1111_1111);
        csr_chk(12'h7C0, 32'd0, "unimpl_csr");

        // mcycle low->high carry
        csr_wr(12'hB00, 32'hFFFF_FFFE);
        csr_wr(12'hB80, 32'd0);
        csr_chk(12'hB00, 32'hFFFF_FFFF, "mcycle_pre_wrap");
        csr_chk(12'hB00, 32'd0, "mcycle_wrap");
        csr_chk(12'hB80, 32'd1, "mcycleh_carry");
        // writing the low half suppresses the carry
        csr_wr(12'hB00, 32'hFFFF_FFFF);
        csr_wr(12'hB00, 32'h0000_0010);
        csr_chk(12'hB80, 32'd1, "mcycleh_nocarry");
        // full 64-bit wrap
        csr_wr(12'hB80, 32'hFFFF_FFFF);
        csr_wr(12'hB00, 32'hFFFF_FFFF);
        csr_chk(12'hB80, 32'hFFFF_FFFF, "mcycleh_pre_wrap");
        csr_chk(12'hB80, 32'd0, "mcycle64_wrap");

        // asynchronous reset mid-cycle with a pending trap
        csr_wr(12'h300, 32'h0000_0008);
        csr_addr   = 12'h341;
        trap_valid = 1'b1; trap_pc = 32'h0000_0444; trap_cause = 32'd7;
        rst_n      = 1'b0;
        expect_val(2, 32'd0, "async_rst_mepc_csr");
        expect_val(4, 32'd0, "async_rst_mepc_out");
        expect_val(5, 32'h8000_0000, "async_rst_mtvec");
        expect_val(6, 32'd0, "async_rst_mie");
        expect_val(3, 32'd0, "async_rst_a0");
        step();
        expect_val(4, 32'd0, "rst_trap_dropped");
        csr_chk(12'h300, 32'h0000_1800, "rst_mstatus2");
        trap_valid = 1'b0;
        rst_n      = 1'b1;

        // minstret
        retire = 1'b1;
        step(); step(); step();
        retire = 1'b0;
        csr_chk(12'hB02, 32'd3, "minstret_3");
        csr_chk(12'hB82, 32'd0, "minstreth_0");
        retire = 1'b1;
        csr_wr(12'hB02, 32'hFFFF_FFFF);
        csr_chk(12'hB02, 32'hFFFF_FFFF, "minstret_load_over_inc");
        retire = 1'b0;
        csr_chk(12'hB82, 32'd1, "minstreth_carry");
        csr_chk(12'hB02, 32'd0, "minstret_wrap_low");

        step();
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL timeout: got running expected finished");
            $fatal(1, "timeout");
        end
    end

endmodule

// File: doc/ysyx_25040109_regfile_csr.md
YSYX_25040109_REGFILE_CSR -- requirements
Module: ysyx_25040109_regfile_csr

Interface
REQ-001 Parameters SHALL be: NREGS, 32, GPR count (16 = RV32E or 32); BYPASS, 0, 1 = write-to-read forwarding; MTVEC_RST, 32'h8000_0000, mtvec reset value.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low; the block uses one clock.
REQ-004 wen / waddr / wdata  in  1/5/32  GPR write port.
REQ-005 raddr1 / raddr2  in  5 each  GPR read addresses; rdata1 / rdata2  out  32 each  read data.
REQ-006 a0_out  out  32  current x10 value.
REQ-007 csr_we / csr_addr / csr_wdata  in  1/12/32  CSR write port; csr_rdata  out  32  CSR read of csr_addr.
REQ-008 trap_valid / trap_pc / trap_cause  in  1/32/32  synchronous exception entry request.
REQ-009 mret  in  1  trap return; retire  in  1  one instruction retired this cycle.
REQ-010 mepc_out / mtvec_out  out  32 each  mepc and {mtvec[31:2],2'b00}; mie_out  out  1  mstatus.MIE.

Function
REQ-011 GPR reads SHALL be combinational; address 0, or any address >= NREGS, reads 0.
REQ-012 GPR writes SHALL commit on the rising clk edge when wen=1 and waddr is nonzero and < NREGS; all other writes are dropped.
REQ-013 BYPASS=1: a read whose address equals waddr while wen=1 and the write is legal SHALL return wdata in the same cycle. BYPASS=0: the read returns the old value.
REQ-014 CSRs implemented: mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82; any other address reads 0 and ignores writes.
REQ-015 mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; all other bits read 0.
REQ-016 mepc writes SHALL force bits [1:0] to 0.
REQ-017 Trap (trap_valid=1) at an edge: mepc<=trap_pc with [1:0] cleared; mcause<=trap_cause; MPIE<=MIE; MIE<=0.
REQ-018 mret=1 at an edge (no trap): MIE<=MPIE; MPIE<=1.
REQ-019 Same-cycle priority: trap_valid > mret > csr_we for every CSR that trap or mret modifies; csr_we to other CSRs still commits.
REQ-020 mcycle SHALL be a 64-bit counter, {mcycleh,mcycle}, that increments by 1 every cycle out of reset and wraps from 2^64-1 to 0.
REQ-021 minstret SHALL be a 64-bit counter that increments by 1 on each edge with retire=1 and wraps from 2^64-1 to 0.
REQ-022 A csr_we to a counter half SHALL load csr_wdata into that half, replacing the increment for that cycle; the other half is unaffected, with no carry into it that cycle.
REQ-023 The low-half increment SHALL carry into the high half when low = 32'hFFFF_FFFF.
REQ-024 csr_rdata SHALL be combinational and show pre-edge register values, with no CSR bypass.

Reset
REQ-025 While rst_n=0: all GPRs = 0; mstatus = 32'h1800; mtvec = MTVEC_RST; mscratch, mepc, mcause = 0; both counters = 0; mie_out = 0.
REQ-026 Reset SHALL take effect immediately regardless of clk. The first increment of mcycle occurs on the first rising edge after rst_n deasserts.
REQ-027 A trap or write pending when reset asserts SHALL be discarded.

Verification
REQ-028 Write x5=0xDEADBEEF, then write x0=0x1234 -> next cycle rdata1(raddr=5)=0xDEADBEEF and rdata2(raddr=0)=0. With NREGS=16, a write to x20 reads back 0.
REQ-029 BYPASS=1, same cycle wen=1 waddr=7 wdata=0xA5A5A5A5 raddr1=7 -> rdata1=0xA5A5A5A5 that cycle. BYPASS=0 -> old value 0.
REQ-030 Set MIE=1 (csr write 0x300 with 0x8); then trap_valid with pc=0x80000123, cause=11, and a csr write mcause=5 in the same cycle -> mepc=0x80000120, mcause=11, mstatus=0x1880, mie_out=0. Then mret -> mstatus=0x1888.
REQ-031 Write mcycle=0xFFFFFFFE and mcycleh=0 -> two cycles later mcycle=0 and mcycleh=1.
REQ-032 Pulse retire for 3 cycles from reset -> minstret=3 and minstreth=0. Assert rst_n=0 between edges -> all CSRs return to their reset values immediately.
